// File: rtl/lpddr2_avl_arbiter_pkg.sv
// Shared types and helpers for the LPDDR2 Avalon-MM arbiter.
// Contents: FSM state enum, read-tag record, round-robin pick function.
// The tag fields are sized for the largest supported configuration
// (8 ports, burstcount up to 8 bits) so that the package stays
// parameter-free. Narrower configurations leave the upper bits at zero.
package lpddr2_avl_arb_pkg;

    localparam int TAG_PORT_W  = 3;
    localparam int TAG_BEATS_W = 8;
    localparam int MAX_PORTS   = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD     = 2'd1,
        WR_DATA = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [TAG_PORT_W-1:0]  port;
        logic [TAG_BEATS_W-1:0] beats;
    } tag_t;

    typedef struct packed {
        logic                  found;
        logic [TAG_PORT_W-1:0] idx;
    } pick_t;

    // Search starts at ptr and wraps at nports; the first eligible port wins.
    // ptr < nports and k < nports keep the sum below 2*nports, so a single
    // conditional subtract replaces a modulo.
    function automatic pick_t rr_pick(input logic [MAX_PORTS-1:0]  elig,
                                      input logic [TAG_PORT_W-1:0] ptr,
                                      input logic [3:0]            nports);
        pick_t      res;
        logic [3:0] idx;
        res.found = 1'b0;
        res.idx   = '0;
        for (int k = 0; k < MAX_PORTS; k++) begin
            idx = {1'b0, ptr} + 4'(k);
            if (idx >= nports) idx = idx - nports;
            if (!res.found && (4'(k) < nports) && elig[idx[TAG_PORT_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = idx[TAG_PORT_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/lpddr2_avl_tag_fifo.sv
// Synchronous FIFO holding the read tags of commands in flight.
// Ports:
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_push, i_push_data   write side (ignored when full)
//   i_pop                 drop the head entry (ignored when empty)
//   o_head                head entry, combinational
//   o_full, o_empty       occupancy flags
// Push and pop in the same cycle are both honoured.
module lpddr2_avl_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 11
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_wr_en;
    logic             w_rd_en;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_wr_en = i_push && !o_full;
    assign w_rd_en = i_pop && !o_empty;
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end

endmodule

// File: rtl/lpddr2_avl_arbiter.sv
// N-port Avalon-MM arbiter in front of the LPDDR2 controller avl_0 port.
// Round-robin grant, multi-beat write bursts, in-order read-return routing.
// Ports (client i occupies slice i of every packed s_* bus):
//   clk_clk, reset_reset_n            clock, synchronous active-low reset
//   s_read/s_write/s_address/...      client command inputs
//   s_waitrequest_n, s_readdatavalid  per-client accept and read-beat strobes
//   s_readdata                        read data broadcast to all clients
//   m_*                               controller-side Avalon master
//   err_orphan                        sticky: read beat with nothing outstanding
module lpddr2_avl_arbiter
    import lpddr2_avl_arb_pkg::*;
#(
    parameter int  NUM_PORTS       = 2,
    parameter int  ADDR_W          = 27,
    parameter int  DATA_W          = 32,
    parameter int  BURST_W         = 4,
    parameter int  MAX_OUTSTANDING = 4,
    localparam int BE_W            = DATA_W / 8
) (
    input  logic                           clk_clk,
    input  logic                           reset_reset_n,
    input  logic [NUM_PORTS-1:0]           s_read,
    input  logic [NUM_PORTS-1:0]           s_write,
    input  logic [NUM_PORTS*ADDR_W-1:0]    s_address,
    input  logic [NUM_PORTS*DATA_W-1:0]    s_writedata,
    input  logic [NUM_PORTS*BE_W-1:0]      s_byteenable,
    input  logic [NUM_PORTS*BURST_W-1:0]   s_burstcount,
    output logic [NUM_PORTS-1:0]           s_waitrequest_n,
    output logic [NUM_PORTS-1:0]           s_readdatavalid,
    output logic [DATA_W-1:0]              s_readdata,
    output logic                           m_read,
    output logic                           m_write,
    output logic                           m_beginbursttransfer,
    output logic [ADDR_W-1:0]              m_address,
    output logic [DATA_W-1:0]              m_writedata,
    output logic [BE_W-1:0]                m_byteenable,
    output logic [BURST_W-1:0]             m_burstcount,
    input  logic                           m_waitrequest_n,
    input  logic                           m_readdatavalid,
    input  logic [DATA_W-1:0]              m_readdata,
    output logic                           err_orphan
);
    arb_state_t            r_state;
    logic [TAG_PORT_W-1:0] r_grant;
    logic [TAG_PORT_W-1:0] r_rr_ptr;
    logic [BURST_W-1:0]    r_beats_left;
    logic [BURST_W-1:0]    r_rd_cnt;
    logic                  r_err_orphan;

    logic                  w_g_read, w_g_write;
    logic [ADDR_W-1:0]     w_g_addr;
    logic [DATA_W-1:0]     w_g_wdata;
    logic [BE_W-1:0]       w_g_be;
    logic [BURST_W-1:0]    w_g_bc, w_g_beats;
    logic                  w_g_is_rd, w_g_is_wr;
    logic [MAX_PORTS-1:0]  w_elig;
    pick_t                 w_pick;
    logic                  w_active, w_accept;
    logic [TAG_PORT_W-1:0] w_next_ptr;
    tag_t                  w_push_tag, w_head;
    logic                  w_fifo_full, w_fifo_empty;
    logic                  w_push, w_rd_hit, w_rd_last;

    always_comb begin
        w_g_read  = 1'b0;
        w_g_write = 1'b0;
        w_g_addr  = '0;
        w_g_wdata = '0;
        w_g_be    = '0;
        w_g_bc    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (r_grant == TAG_PORT_W'(i)) begin
                w_g_read  = s_read[i];
                w_g_write = s_write[i];
                w_g_addr  = s_address[i*ADDR_W +: ADDR_W];
                w_g_wdata = s_writedata[i*DATA_W +: DATA_W];
                w_g_be    = s_byteenable[i*BE_W +: BE_W];
                w_g_bc    = s_burstcount[i*BURST_W +: BURST_W];
            end
        end
    end

    assign w_g_beats = (w_g_bc == '0) ? BURST_W'(1) : w_g_bc;
    assign w_g_is_wr = w_g_write;
    assign w_g_is_rd = w_g_read && !w_g_write;

    // A full tag FIFO blocks new reads only; writes keep flowing.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_elig[i] = s_write[i] || (s_read[i] && !w_fifo_full);
        end
    end

    assign w_pick     = rr_pick(w_elig, r_rr_ptr, 4'(NUM_PORTS));
    assign w_next_ptr = (r_grant == TAG_PORT_W'(NUM_PORTS - 1)) ? '0 : r_grant + 1'b1;

    assign w_active             = (r_state != IDLE);
    assign m_read               = (r_state == CMD) && w_g_is_rd;
    assign m_write              = w_active && w_g_is_wr;
    assign m_beginbursttransfer = (r_state == CMD) && (m_read || m_write);
    assign m_address            = w_active ? w_g_addr  : '0;
    assign m_writedata          = w_active ? w_g_wdata : '0;
    assign m_byteenable         = w_active ? w_g_be    : '0;
    assign m_burstcount         = w_active ? w_g_beats : '0;
    assign w_accept             = m_waitrequest_n && (m_read || m_write);

    assign w_push           = w_accept && m_read;
    assign w_push_tag.port  = r_grant;
    assign w_push_tag.beats = TAG_BEATS_W'(w_g_beats);
    assign w_rd_hit         = m_readdatavalid && !w_fifo_empty;
    assign w_rd_last        = (TAG_BEATS_W'(r_rd_cnt) + TAG_BEATS_W'(1)) == w_head.beats;
    assign s_readdata       = w_rd_hit ? m_readdata : '0;
    assign err_orphan       = r_err_orphan;

    always_comb begin
        s_waitrequest_n = '0;
        s_readdatavalid = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            s_waitrequest_n[i] = w_active && (r_grant == TAG_PORT_W'(i)) && m_waitrequest_n;
            s_readdatavalid[i] = w_rd_hit && (w_head.port == TAG_PORT_W'(i));
        end
    end

    lpddr2_avl_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH ($bits(tag_t))
    ) u_tag_fifo (
        .i_clk       (clk_clk),
        .i_rst_n     (reset_reset_n),
        .i_push      (w_push),
        .i_push_data (w_push_tag),
        .i_pop       (w_rd_hit && w_rd_last),
        .o_head      (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_rr_ptr     <= '0;
            r_beats_left <= '0;
            r_rd_cnt     <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick.found) begin
                        r_grant <= w_pick.idx;
                        r_state <= CMD;
                    end
                end
                CMD: begin
                    if (w_accept) begin
                        if (m_write && (w_g_beats != BURST_W'(1))) begin
                            r_beats_left <= w_g_beats - BURST_W'(1);
                            r_state      <= WR_DATA;
                        end else begin
                            r_rr_ptr <= w_next_ptr;
                            r_state  <= IDLE;
                        end
                    end else if (!w_g_read && !w_g_write) begin
                        // Client withdrew its request before acceptance.
                        r_state <= IDLE;
                    end
                end
                WR_DATA: begin
                    if (w_accept) begin
                        r_beats_left <= r_beats_left - BURST_W'(1);
                        if (r_beats_left == BURST_W'(1)) begin
                            r_rr_ptr <= w_next_ptr;
                            r_state  <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_rd_hit) r_rd_cnt <= w_rd_last ? '0 : r_rd_cnt + BURST_W'(1);
            if (m_readdatavalid && w_fifo_empty) r_err_orphan <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lpddr2_avl_arbiter.sv
module tb_lpddr2_avl_arbiter;
    localparam int NP  = 2;
    localparam int AW  = 27;
    localparam int DW  = 32;
    localparam int BW  = 4;
    localparam int BEW = DW / 8;

    logic               clk_clk = 1'b0;
    logic               reset_reset_n;
    logic [NP-1:0]      s_read, s_write;
    logic [NP*AW-1:0]   s_address;
    logic [NP*DW-1:0]   s_writedata;
    logic [NP*BEW-1:0]  s_byteenable;
    logic [NP*BW-1:0]   s_burstcount;
    logic [NP-1:0]      s_waitrequest_n, s_readdatavalid;
    logic [DW-1:0]      s_readdata;
    logic               m_read, m_write, m_beginbursttransfer;
    logic [AW-1:0]      m_address;
    logic [DW-1:0]      m_writedata;
    logic [BEW-1:0]     m_byteenable;
    logic [BW-1:0]      m_burstcount;
    logic               m_waitrequest_n, m_readdatavalid;
    logic [DW-1:0]      m_readdata;
    logic               err_orphan;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk_clk = ~clk_clk;

    lpddr2_avl_arbiter #(
        .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .BURST_W(BW), .MAX_OUTSTANDING(4)
    ) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .s_read(s_read), .s_write(s_write), .s_address(s_address),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable), .s_burstcount(s_burstcount),
        .s_waitrequest_n(s_waitrequest_n), .s_readdatavalid(s_readdatavalid), .s_readdata(s_readdata),
        .m_read(m_read), .m_write(m_write), .m_beginbursttransfer(m_beginbursttransfer),
        .m_address(m_address), .m_writedata(m_writedata), .m_byteenable(m_byteenable),
        .m_burstcount(m_burstcount), .m_waitrequest_n(m_waitrequest_n),
        .m_readdatavalid(m_readdatavalid), .m_readdata(m_readdata), .err_orphan(err_orphan)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 2 time units after the next rising edge.
    task automatic cyc();
        @(posedge clk_clk);
        #2;
    endtask

    task automatic set_port(input int p, input logic rd, input logic wr,
                            input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [BW-1:0] bc);
        s_read[p]                  = rd;
        s_write[p]                 = wr;
        s_address[p*AW +: AW]      = addr;
        s_writedata[p*DW +: DW]    = data;
        s_byteenable[p*BEW +: BEW] = '1;
        s_burstcount[p*BW +: BW]   = bc;
    endtask

    int   beats;
    logic acc;
    logic [AW-1:0] exp_addr [4];

    initial begin
        reset_reset_n   = 1'b0;
        s_read          = '0;
        s_write         = '0;
        s_address       = '0;
        s_writedata     = '0;
        s_byteenable    = '0;
        s_burstcount    = '0;
        m_waitrequest_n = 1'b1;
        m_readdatavalid = 1'b0;
        m_readdata      = 32'hA5A5_A5A5;

        // Reset values
        cyc(); cyc();
        #1;
        chk("rst_m_read", m_read, 0);
        chk("rst_m_write", m_write, 0);
        chk("rst_begin", m_beginbursttransfer, 0);
        chk("rst_wrn", s_waitrequest_n, 0);
        chk("rst_rdv", s_readdatavalid, 0);
        chk("rst_rdata", s_readdata, 0);
        chk("rst_addr", m_address, 0);
        chk("rst_orphan", err_orphan, 0);
        cyc();
        reset_reset_n = 1'b1;
        m_readdata    = '0;

        // Port0 single write
        set_port(0, 1'b0, 1'b1, 27'h100, 32'hDEAD_BEEF, 4'd1);
        #1;
        chk("a_idle_write", m_write, 0);
        cyc(); #1;
        chk("a_m_write", m_write, 1);
        chk("a_m_read", m_read, 0);
        chk("a_addr", m_address, 27'h100);
        chk("a_wdata", m_writedata, 32'hDEAD_BEEF);
        chk("a_be", m_byteenable, 4'hF);
        chk("a_bc", m_burstcount, 1);
        chk("a_begin", m_beginbursttransfer, 1);
        chk("a_wrn", s_waitrequest_n, 2'b01);
        cyc();
        set_port(0, 1'b0, 1'b0, 27'h100, 32'hDEAD_BEEF, 4'd1);
        #1;
        chk("a_done_write", m_write, 0);
        chk("a_done_wrn", s_waitrequest_n, 0);

        // Both ports writing continuously: rr_ptr is 1 after port0's write
        exp_addr[0] = 27'h20; exp_addr[1] = 27'h10;
        exp_addr[2] = 27'h20; exp_addr[3] = 27'h10;
        set_port(0, 1'b0, 1'b1, 27'h10, 32'h1111_0000, 4'd1);
        set_port(1, 1'b0, 1'b1, 27'h20, 32'h2222_0000, 4'd1);
        for (int k = 0; k < 4; k++) begin
            cyc(); #1;
            chk("b_addr", m_address, exp_addr[k]);
            chk("b_wrn", s_waitrequest_n, (k % 2 == 0) ? 2'b10 : 2'b01);
            cyc();
        end
        set_port(0, 1'b0, 1'b0, 27'h10, 32'h0, 4'd1);
        set_port(1, 1'b0, 1'b0, 27'h20, 32'h0, 4'd1);
        cyc();

        // Port1 burst of 4 with toggling waitrequest; port0 waits
        set_port(0, 1'b0, 1'b1, 27'h40, 32'h0000_0011, 4'd1);
        set_port(1, 1'b0, 1'b1, 27'h300, 32'h0000_00C0, 4'd4);
        beats = 0;
        acc   = 1'b0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            if (acc) s_writedata[DW +: DW] = 32'hC0 + 32'(beats);
            acc = 1'b0;
            m_waitrequest_n = (c % 2 == 1);
            #1;
            chk("c_p0_blocked", s_waitrequest_n[0], 0);
            if (s_waitrequest_n[1]) begin
                chk("c_wdata", m_writedata, 32'hC0 + 32'(beats));
                chk("c_addr", m_address, 27'h300);
                chk("c_begin", m_beginbursttransfer, (beats == 0));
                beats++;
                acc = 1'b1;
            end
            if (beats == 4) break;
        end
        chk("c_beat_count", beats, 4);
        cyc();
        set_port(1, 1'b0, 1'b0, 27'h300, 32'h0, 4'd4);
        m_waitrequest_n = 1'b1;
        cyc(); #1;
        chk("c_p0_addr", m_address, 27'h40);
        chk("c_p0_wrn", s_waitrequest_n, 2'b01);
        cyc();
        set_port(0, 1'b0, 1'b0, 27'h40, 32'h0, 4'd1);

        // Reads: port0 burst 2, then port1 burst 3, then 5 return beats
        set_port(0, 1'b1, 1'b0, 27'h500, 32'h0, 4'd2);
        cyc(); #1;
        chk("d_p0_read", m_read, 1);
        chk("d_p0_bc", m_burstcount, 2);
        chk("d_p0_begin", m_beginbursttransfer, 1);
        cyc();
        set_port(0, 1'b0, 1'b0, 27'h500, 32'h0, 4'd2);
        set_port(1, 1'b1, 1'b0, 27'h600, 32'h0, 4'd3);
        cyc(); #1;
        chk("d_p1_read", m_read, 1);
        chk("d_p1_addr", m_address, 27'h600);
        chk("d_p1_bc", m_burstcount, 3);
        cyc();
        set_port(1, 1'b0, 1'b0, 27'h600, 32'h0, 4'd3);
        for (int b = 0; b < 5; b++) begin
            m_readdatavalid = 1'b1;
            m_readdata      = 32'hD0 + 32'(b);
            #1;
            chk("d_rdv", s_readdatavalid, (b < 2) ? 2'b01 : 2'b10);
            chk("d_rdata", s_readdata, 32'hD0 + 32'(b));
            cyc();
        end
        m_readdatavalid = 1'b0;
        #1;
        chk("d_no_orphan", err_orphan, 0);

        // Four outstanding reads fill the tag FIFO; the fifth waits
        set_port(0, 1'b1, 1'b0, 27'h700, 32'h0, 4'd1);
        for (int k = 0; k < 4; k++) begin
            cyc(); #1;
            chk("e_read", m_read, 1);
            chk("e_wrn", s_waitrequest_n, 2'b01);
            cyc();
        end
        cyc(); #1;
        chk("e_full_block", m_read, 0);
        chk("e_full_wrn", s_waitrequest_n, 0);
        set_port(1, 1'b0, 1'b1, 27'h800, 32'h0000_0800, 4'd1);
        cyc(); #1;
        chk("e_wr_granted", m_write, 1);
        chk("e_wr_addr", m_address, 27'h800);
        chk("e_wr_no_read", m_read, 0);
        cyc();
        set_port(1, 1'b0, 1'b0, 27'h800, 32'h0, 4'd1);
        cyc(); #1;
        chk("e_still_block", m_read, 0);
        m_readdatavalid = 1'b1;
        m_readdata      = 32'hE0;
        #1;
        chk("e_ret_rdv", s_readdatavalid, 2'b01);
        cyc();
        m_readdatavalid = 1'b0;
        #1;
        chk("e_pop_edge_idle", m_read, 0);
        cyc(); #1;
        chk("e_fifth_read", m_read, 1);
        chk("e_fifth_wrn", s_waitrequest_n, 2'b01);
        cyc();
        set_port(0, 1'b0, 1'b0, 27'h700, 32'h0, 4'd1);
        for (int b = 0; b < 4; b++) begin
            m_readdatavalid = 1'b1;
            m_readdata      = 32'hF0 + 32'(b);
            #1;
            chk("e_drain_rdv", s_readdatavalid, 2'b01);
            cyc();
        end
        m_readdatavalid = 1'b0;

        // burstcount 0 behaves as a single beat
        set_port(0, 1'b0, 1'b1, 27'h900, 32'h0000_0900, 4'd0);
        cyc(); #1;
        chk("g_bc0", m_burstcount, 1);
        cyc();
        set_port(0, 1'b0, 1'b0, 27'h900, 32'h0, 4'd0);
        #1;
        chk("g_bc0_idle_wrn", s_waitrequest_n, 0);
        cyc();

        // Orphan read beat
        m_readdatavalid = 1'b1;
        m_readdata      = 32'h1234_5678;
        #1;
        chk("f_orphan_rdv", s_readdatavalid, 0);
        chk("f_orphan_rdata", s_readdata, 0);
        cyc();
        m_readdatavalid = 1'b0;
        #1;
        chk("f_orphan_set", err_orphan, 1);
        cyc(); cyc(); #1;
        chk("f_orphan_sticky", err_orphan, 1);
        reset_reset_n = 1'b0;
        cyc();
        reset_reset_n = 1'b1;
        #1;
        chk("f_orphan_clr", err_orphan, 0);
        chk("f_rst_write", m_write, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
